axi_bridge_arb: RTL and testbench

- Parametrised successor to the single-requestor cache-to-AXI bridge.
- Arbitrates NCH cache/uncached requestors (icache, dcache, later uncached store buffer) onto one AXI3 master port.
- Independent read and write engines, so one read burst and one write burst can be in flight at once.
- Cached requests move a full line as an INCR burst of LINE_WORDS beats. Uncached requests move a single beat with caller-supplied size and strobe.

---
 rtl/axi_pkg.sv | 40 ++++
 rtl/rr_arbiter.sv | 33 +++
 rtl/axi_bridge_arb.sv | 262 ++++++++++++++++++++++++++
 tb/tb_axi_bridge_arb.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: AXI3 field widths, encodings and FSM state types
// shared by the cache-to-AXI bridge and its arbiters.
package axi_pkg;

  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int LOCK_W  = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int RESP_W  = 2;

  localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;

  localparam logic [SIZE_W-1:0] SIZE_1B  = 3'd0;
  localparam logic [SIZE_W-1:0] SIZE_2B  = 3'd1;
  localparam logic [SIZE_W-1:0] SIZE_4B  = 3'd2;
  localparam logic [SIZE_W-1:0] SIZE_8B  = 3'd3;
  localparam logic [SIZE_W-1:0] SIZE_16B = 3'd4;

  function automatic logic [SIZE_W-1:0] size_enc(input int bytes);
    return SIZE_W'($clog2(bytes));
  endfunction

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA,
    R_DONE
  } rd_state_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_AW,
    W_DATA,
    W_RESP,
    W_DONE
  } wr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: pointer-based round-robin arbiter, one-hot grant.
// The search starts at ptr and wraps to channel 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic found;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && PW'(i) >= ptr) begin
        found = 1'b1;
        idx   = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        idx   = PW'(i);
      end
    end
    gnt = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/axi_bridge_arb.sv
// axi_bridge_arb: arbitrates NCH cached/uncached requestors onto one AXI3
// master with independent read and write engines.
module axi_bridge_arb
  import axi_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NCH-1:0]                 req_valid,
  output logic [NCH-1:0]                 req_ready,
  input  logic [NCH-1:0]                 req_write,
  input  logic [NCH-1:0]                 req_cached,
  input  logic [NCH*3-1:0]               req_size,
  input  logic [NCH*ADDR_W-1:0]          req_addr,
  input  logic [NCH*DATA_W/8-1:0]        req_wstrb,
  input  logic [NCH*LINE_WORDS*DATA_W-1:0] req_wdata,
  output logic [NCH-1:0]                 rd_done,
  output logic [LINE_WORDS*DATA_W-1:0]   rd_data,
  output logic                           rd_err,
  output logic [NCH-1:0]                 wr_done,
  output logic                           wr_err,
  output logic [ID_W-1:0]                arid,
  output logic [ADDR_W-1:0]              araddr,
  output logic [3:0]                     arlen,
  output logic [2:0]                     arsize,
  output logic [1:0]                     arburst,
  output logic [1:0]                     arlock,
  output logic [3:0]                     arcache,
  output logic [2:0]                     arprot,
  output logic                           arvalid,
  input  logic                           arready,
  output logic [ID_W-1:0]                awid,
  output logic [ADDR_W-1:0]              awaddr,
  output logic [3:0]                     awlen,
  output logic [2:0]                     awsize,
  output logic [1:0]                     awburst,
  output logic [1:0]                     awlock,
  output logic [3:0]                     awcache,
  output logic [2:0]                     awprot,
  output logic                           awvalid,
  input  logic                           awready,
  output logic [ID_W-1:0]                wid,
  output logic [DATA_W-1:0]              wdata,
  output logic [DATA_W/8-1:0]            wstrb,
  output logic                           wlast,
  output logic                           wvalid,
  input  logic                           wready,
  input  logic [ID_W-1:0]                rid,
  input  logic [DATA_W-1:0]              rdata,
  input  logic [1:0]                     rresp,
  input  logic                           rlast,
  input  logic                           rvalid,
  output logic                           rready,
  input  logic [ID_W-1:0]                bid,
  input  logic [1:0]                     bresp,
  input  logic                           bvalid,
  output logic                           bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW     = $clog2(LINE_WORDS);
  localparam int LINE_B = LINE_WORDS * STRB_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_B - 1);
  localparam logic [LEN_W-1:0]  LINE_LEN  = LEN_W'(LINE_WORDS - 1);
  localparam logic [SIZE_W-1:0] FULL_SIZE = size_enc(STRB_W);

  typedef struct packed {
    logic                              write;
    logic                              cached;
    logic [SIZE_W-1:0]                 size;
    logic [ADDR_W-1:0]                 addr;
    logic [STRB_W-1:0]                 wstrb;
    logic [LINE_WORDS-1:0][DATA_W-1:0] wdata;
  } req_t;

  req_t           req [NCH];
  logic [NCH-1:0] hazard;
  logic [NCH-1:0] rd_cand, wr_cand;
  logic [NCH-1:0] rd_arb, wr_arb;
  logic [NCH-1:0] rd_gnt, wr_gnt;
  logic [CW-1:0]  rd_idx, wr_idx;
  logic           rd_acc, wr_acc;

  rd_state_e rs, rs_n;
  wr_state_e ws, ws_n;

  logic [CW-1:0]                     rptr, wptr, r_own, w_own;
  logic [ADDR_W-1:0]                 r_addr, w_addr;
  logic [LEN_W-1:0]                  r_len, w_len, r_cnt, w_cnt;
  logic [SIZE_W-1:0]                 r_size, w_size;
  logic [STRB_W-1:0]                 w_strb;
  logic [LINE_WORDS-1:0][DATA_W-1:0] r_buf, w_buf;
  logic                              r_err, w_err;
  logic                              r_beat, b_hit;

  function automatic logic [CW-1:0] nxt(input logic [CW-1:0] i);
    return (i == CW'(NCH - 1)) ? '0 : CW'(i + 1'b1);
  endfunction

  // Reads to the line a pending write targets must wait for that write.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      req[i].write  = req_write[i];
      req[i].cached = req_cached[i];
      req[i].size   = req_size[i*3 +: 3];
      req[i].addr   = req_addr[i*ADDR_W +: ADDR_W];
      req[i].wstrb  = req_wstrb[i*STRB_W +: STRB_W];
      req[i].wdata  = req_wdata[i*LINE_WORDS*DATA_W +: LINE_WORDS*DATA_W];
      hazard[i]  = (ws != W_IDLE) &&
                   ((req[i].addr & LINE_MASK) == (w_addr & LINE_MASK));
      rd_cand[i] = req_valid[i] && !req[i].write && !hazard[i];
      wr_cand[i] = req_valid[i] && req[i].write;
    end
  end

  rr_arbiter #(.N(NCH)) u_rd_arb (
    .req (rd_cand),
    .ptr (rptr),
    .gnt (rd_arb),
    .idx (rd_idx)
  );

  rr_arbiter #(.N(NCH)) u_wr_arb (
    .req (wr_cand),
    .ptr (wptr),
    .gnt (wr_arb),
    .idx (wr_idx)
  );

  assign rd_gnt    = (!rst && rs == R_IDLE) ? rd_arb : '0;
  assign wr_gnt    = (!rst && ws == W_IDLE) ? wr_arb : '0;
  assign rd_acc    = |rd_gnt;
  assign wr_acc    = |wr_gnt;
  assign req_ready = rd_gnt | wr_gnt;

  assign r_beat = (rs == R_DATA) && rvalid && (rid == ID_W'(r_own));
  assign b_hit  = (ws == W_RESP) && bvalid && (bid == ID_W'(w_own));

  always_comb begin
    rs_n = rs;
    unique case (rs)
      R_IDLE:  if (rd_acc) rs_n = R_ADDR;
      R_ADDR:  if (arready) rs_n = R_DATA;
      R_DATA:  if (r_beat && (rlast || r_cnt == r_len)) rs_n = R_DONE;
      R_DONE:  rs_n = R_IDLE;
      default: rs_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs     <= R_IDLE;
      rptr   <= '0;
      r_own  <= '0;
      r_addr <= '0;
      r_len  <= '0;
      r_size <= '0;
      r_cnt  <= '0;
      r_buf  <= '0;
      r_err  <= 1'b0;
    end else begin
      rs <= rs_n;
      if (rd_acc) begin
        rptr   <= nxt(rd_idx);
        r_own  <= rd_idx;
        r_addr <= req[rd_idx].cached ? (req[rd_idx].addr & LINE_MASK)
                                     : req[rd_idx].addr;
        r_len  <= req[rd_idx].cached ? LINE_LEN : '0;
        r_size <= req[rd_idx].cached ? FULL_SIZE : req[rd_idx].size;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end else if (r_beat) begin
        r_buf[r_cnt[BW-1:0]] <= rdata;
        r_cnt <= r_cnt + 1'b1;
        if (rresp != 2'b00) r_err <= 1'b1;
      end
    end
  end

  assign arid    = ID_W'(r_own);
  assign araddr  = r_addr;
  assign arlen   = r_len;
  assign arsize  = r_size;
  assign arburst = BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arvalid = (rs == R_ADDR);
  assign rready  = (rs == R_DATA);
  assign rd_done = (rs == R_DONE) ? (NCH'(1) << r_own) : '0;
  assign rd_err  = (rs == R_DONE) && r_err;
  assign rd_data = r_buf;

  always_comb begin
    ws_n = ws;
    unique case (ws)
      W_IDLE:  if (wr_acc) ws_n = W_AW;
      W_AW:    if (awready) ws_n = W_DATA;
      W_DATA:  if (wready && w_cnt == w_len) ws_n = W_RESP;
      W_RESP:  if (b_hit) ws_n = W_DONE;
      W_DONE:  ws_n = W_IDLE;
      default: ws_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ws     <= W_IDLE;
      wptr   <= '0;
      w_own  <= '0;
      w_addr <= '0;
      w_len  <= '0;
      w_size <= '0;
      w_strb <= '0;
      w_cnt  <= '0;
      w_buf  <= '0;
      w_err  <= 1'b0;
    end else begin
      ws <= ws_n;
      if (wr_acc) begin
        wptr   <= nxt(wr_idx);
        w_own  <= wr_idx;
        w_addr <= req[wr_idx].cached ? (req[wr_idx].addr & LINE_MASK)
                                     : req[wr_idx].addr;
        w_len  <= req[wr_idx].cached ? LINE_LEN : '0;
        w_size <= req[wr_idx].cached ? FULL_SIZE : req[wr_idx].size;
        w_strb <= req[wr_idx].cached ? '1 : req[wr_idx].wstrb;
        w_buf  <= req[wr_idx].wdata;
        w_cnt  <= '0;
        w_err  <= 1'b0;
      end else begin
        if (ws == W_DATA && wready) w_cnt <= w_cnt + 1'b1;
        if (b_hit && bresp != 2'b00) w_err <= 1'b1;
      end
    end
  end

  assign awid    = ID_W'(w_own);
  assign awaddr  = w_addr;
  assign awlen   = w_len;
  assign awsize  = w_size;
  assign awburst = BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign awvalid = (ws == W_AW);
  assign wid     = ID_W'(w_own);
  assign wdata   = w_buf[w_cnt[BW-1:0]];
  assign wstrb   = w_strb;
  assign wvalid  = (ws == W_DATA);
  assign wlast   = (ws == W_DATA) && (w_cnt == w_len);
  assign bready  = (ws == W_RESP);
  assign wr_done = (ws == W_DONE) ? (NCH'(1) << w_own) : '0;
  assign wr_err  = (ws == W_DONE) && w_err;

endmodule

// File: tb/tb_axi_bridge_arb.sv
// tb_axi_bridge_arb: directed bench with a small AXI3 slave model
// and hand-computed expectations for the two-channel bridge.
module tb_axi_bridge_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   req_valid, req_ready, req_write, req_cached;
  logic [5:0]   req_size;
  logic [63:0]  req_addr;
  logic [7:0]   req_wstrb;
  logic [255:0] req_wdata;
  logic [1:0]   rd_done, wr_done;
  logic [127:0] rd_data;
  logic         rd_err, wr_err;
  logic [3:0]   arid, awid, wid, rid, bid;
  logic [31:0]  araddr, awaddr, wdata, rdata;
  logic [3:0]   arlen, awlen, arcache, awcache, wstrb;
  logic [2:0]   arsize, awsize, arprot, awprot;
  logic [1:0]   arburst, awburst, arlock, awlock, rresp, bresp;
  logic         arvalid, arready, awvalid, awready;
  logic         wlast, wvalid, wready, rlast, rvalid, rready, bvalid, bready;

  logic         v [2];
  logic         cw [2];
  logic         cc [2];
  logic [2:0]   cs [2];
  logic [31:0]  ca [2];
  logic [3:0]   cst [2];
  logic [127:0] cd [2];

  assign req_valid  = {v[1], v[0]};
  assign req_write  = {cw[1], cw[0]};
  assign req_cached = {cc[1], cc[0]};
  assign req_size   = {cs[1], cs[0]};
  assign req_addr   = {ca[1], ca[0]};
  assign req_wstrb  = {cst[1], cst[0]};
  assign req_wdata  = {cd[1], cd[0]};

  axi_bridge_arb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_cached(req_cached),
    .req_size(req_size), .req_addr(req_addr),
    .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rd_done(rd_done), .rd_data(rd_data), .rd_err(rd_err),
    .wr_done(wr_done), .wr_err(wr_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          ar_stall = 0;
  bit          wstall   = 1'b0;
  int          err_beat = -1;
  logic [31:0] rd_base  = 32'h0;

  logic [31:0]  ar_addr_q [$];
  logic [3:0]   ar_len_q [$];
  logic [3:0]   ar_id_q [$];
  logic [2:0]   ar_size_q [$];
  logic [10:0]  ar_misc_q [$];
  logic [31:0]  aw_addr_q [$];
  logic [3:0]   aw_len_q [$];
  logic [3:0]   aw_id_q [$];
  logic [2:0]   aw_size_q [$];
  logic [31:0]  wd_q [$];
  logic [3:0]   wst_q [$];
  logic         wl_q [$];
  logic [3:0]   wid_q [$];
  logic [1:0]   rdd_q [$];
  logic [127:0] rdat_q [$];
  logic         rerr_q [$];
  logic [1:0]   wrd_q [$];
  logic         werr_q [$];

  task automatic clear_logs();
    ar_addr_q.delete(); ar_len_q.delete(); ar_id_q.delete();
    ar_size_q.delete(); ar_misc_q.delete();
    aw_addr_q.delete(); aw_len_q.delete(); aw_id_q.delete();
    aw_size_q.delete();
    wd_q.delete(); wst_q.delete(); wl_q.delete(); wid_q.delete();
    rdd_q.delete(); rdat_q.delete(); rerr_q.delete();
    wrd_q.delete(); werr_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst && rd_done != 2'b00) begin
      rdd_q.push_back(rd_done);
      rdat_q.push_back(rd_data);
      rerr_q.push_back(rd_err);
    end
    if (!rst && wr_done != 2'b00) begin
      wrd_q.push_back(wr_done);
      werr_q.push_back(wr_err);
    end
  end

  initial begin : rd_slave
    logic [3:0] id, len;
    arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    forever begin
      @(negedge clk);
      if (arvalid && !rst) begin
        ar_addr_q.push_back(araddr);
        ar_len_q.push_back(arlen);
        ar_id_q.push_back(arid);
        ar_size_q.push_back(arsize);
        ar_misc_q.push_back({arburst, arlock, arcache, arprot});
        repeat (ar_stall) @(negedge clk);
        arready = 1; id = arid; len = arlen;
        @(negedge clk);
        arready = 0;
        for (int b = 0; b <= int'(len) && !rst; b++) begin
          rvalid = 1; rid = id; rdata = rd_base + 32'(b);
          rresp = (b == err_beat) ? 2'd2 : 2'd0;
          rlast = (b == int'(len));
          @(negedge clk);
        end
        rvalid = 0; rlast = 0; rresp = 0;
      end
    end
  end

  initial begin : wr_slave
    logic [3:0] id;
    logic done, ph;
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
    forever begin
      @(negedge clk);
      if (awvalid && !rst) begin
        aw_addr_q.push_back(awaddr);
        aw_len_q.push_back(awlen);
        aw_id_q.push_back(awid);
        aw_size_q.push_back(awsize);
        awready = 1; id = awid;
        @(negedge clk);
        awready = 0; done = 0; ph = 0;
        while (!done && !rst) begin
          wready = wstall ? ph : 1'b1;
          ph = !ph;
          if (wvalid && wready) begin
            wd_q.push_back(wdata); wst_q.push_back(wstrb);
            wl_q.push_back(wlast); wid_q.push_back(wid);
            done = wlast;
          end
          @(negedge clk);
        end
        wready = 0;
        if (!rst) begin
          bvalid = 1; bid = id; bresp = 2'd0;
          @(negedge clk);
          bvalid = 0;
        end
      end
    end
  end

  task automatic issue(input int ch, input logic wr, input logic cached,
                       input logic [2:0] sz, input logic [31:0] a,
                       input logic [3:0] st, input logic [127:0] d);
    int n;
    cw[ch] = wr; cc[ch] = cached; cs[ch] = sz;
    ca[ch] = a; cst[ch] = st; cd[ch] = d;
    v[ch] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[ch] && n < 400) begin
      @(negedge clk); #1; n++;
    end
    chk($sformatf("accept ch%0d", ch), n < 400, 1'b1);
    @(posedge clk); #1;
    v[ch] = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit wr, input int n);
    int k = 0;
    while ((wr ? wrd_q.size() : rdd_q.size()) < n && k < 500) begin
      @(negedge clk); k++;
    end
    chk(tag, k < 500, 1'b1);
  endtask

  task automatic wait_wvalid();
    int k = 0;
    while (!wvalid && k < 100) begin
      @(negedge clk); #1; k++;
    end
    chk("wvalid seen", wvalid, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; v[0] = 0; v[1] = 0;
    repeat (2) @(negedge clk);
    #1 rst = 0;
    clear_logs();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int k, early;
    logic seen;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; cw[i] = 0; cc[i] = 0; cs[i] = 0;
      ca[i] = 0; cst[i] = 0; cd[i] = 0;
    end

    // reset state, with a request held during reset
    repeat (2) @(negedge clk);
    v[0] = 1; #1;
    chk("reset req_ready", req_ready, 2'b00);
    chk("reset outs", {arvalid, awvalid, wvalid, rready, bready,
                       rd_done, wr_done, rd_err, wr_err}, 0);
    chk("reset rd_data", rd_data, 0);
    v[0] = 0;
    @(negedge clk); #1 rst = 0;
    clear_logs();

    // cached read
    rd_base = 32'hA0;
    issue(0, 0, 1, 3'd0, 32'h1C00_0014, 4'h0, 0);
    wait_done("rd1 done", 0, 1);
    repeat (4) @(negedge clk);
    chk("rd1 araddr", ar_addr_q[0], 32'h1C00_0010);
    chk("rd1 arlen", ar_len_q[0], 4'd3);
    chk("rd1 arsize", ar_size_q[0], 3'd2);
    chk("rd1 arid", ar_id_q[0], 4'd0);
    chk("rd1 const", ar_misc_q[0], {2'b01, 9'd0});
    chk("rd1 one pulse", rdd_q.size(), 1);
    chk("rd1 owner", rdd_q[0], 2'b01);
    chk("rd1 data", rdat_q[0], 128'h000000A3_000000A2_000000A1_000000A0);
    chk("rd1 err", rerr_q[0], 1'b0);

    // uncached byte write
    issue(1, 1, 0, 3'd0, 32'hBFAF_0000, 4'b0100, 128'h11223344);
    wait_done("wr1 done", 1, 1);
    chk("wr1 awaddr", aw_addr_q[0], 32'hBFAF_0000);
    chk("wr1 awlen", aw_len_q[0], 4'd0);
    chk("wr1 awsize", aw_size_q[0], 3'd0);
    chk("wr1 awid", aw_id_q[0], 4'd1);
    chk("wr1 beats", wd_q.size(), 1);
    chk("wr1 wstrb", wst_q[0], 4'b0100);
    chk("wr1 wlast", wl_q[0], 1'b1);
    chk("wr1 wdata", wd_q[0], 32'h11223344);
    chk("wr1 wid", wid_q[0], 4'd1);
    chk("wr1 owner", wrd_q[0], 2'b10);

    // round-robin between two continuous readers
    do_reset();
    fork
      begin
        issue(0, 0, 1, 3'd0, 32'h1000, 0, 0);
        issue(0, 0, 1, 3'd0, 32'h1100, 0, 0);
      end
      begin
        issue(1, 0, 1, 3'd0, 32'h2000, 0, 0);
        issue(1, 0, 1, 3'd0, 32'h2100, 0, 0);
      end
    join
    wait_done("rr done", 0, 4);
    chk("rr arid0", ar_id_q[0], 4'd0);
    chk("rr arid1", ar_id_q[1], 4'd1);
    chk("rr arid2", ar_id_q[2], 4'd0);
    chk("rr arid3", ar_id_q[3], 4'd1);
    chk("rr done1", rdd_q[1], 2'b10);
    chk("rr addr2", ar_addr_q[2], 32'h1100);

    // read-after-write hazard on the same line
    do_reset();
    wstall = 1;
    early = 0;
    fork
      issue(1, 1, 1, 3'd0, 32'h100, 0, 128'h4_3_2_1);
      begin
        wait_wvalid();
        cw[0] = 0; cc[0] = 1; ca[0] = 32'h104; v[0] = 1;
        k = 0; seen = 0;
        while (!seen && k < 300) begin
          @(negedge clk); #1; k++;
          if (arvalid || req_ready[0]) early++;
          if (wr_done[1]) seen = 1;
        end
        chk("haz wr_done", seen, 1'b1);
        chk("haz blocked", early, 0);
        @(negedge clk); #1;
        chk("haz grant", req_ready[0], 1'b1);
        @(posedge clk); #1 v[0] = 0;
      end
    join
    wait_done("haz rd done", 0, 1);
    chk("haz araddr", ar_addr_q[0], 32'h100);

    // unrelated read proceeds while the write is in flight
    clear_logs();
    fork
      issue(1, 1, 1, 3'd0, 32'h100, 0, 128'h8_7_6_5);
      begin
        wait_wvalid();
        cw[0] = 0; cc[0] = 1; ca[0] = 32'h200; v[0] = 1; #1;
        chk("unrel ready", {req_ready[0], wvalid}, 2'b11);
        @(posedge clk); #1 v[0] = 0;
      end
    join
    wait_done("unrel rd", 0, 1);
    wait_done("unrel wr", 1, 1);
    chk("unrel araddr", ar_addr_q[0], 32'h200);

    // backpressure, simultaneous accept and read error
    do_reset();
    ar_stall = 5; wstall = 1; err_beat = 2; rd_base = 32'hB0;
    fork
      issue(0, 0, 1, 3'd0, 32'h304, 0, 0);
      issue(1, 1, 1, 3'd0, 32'h400, 4'h0,
            128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
      begin
        #1 chk("dual accept", req_ready, 2'b11);
      end
    join
    wait_done("bp rd", 0, 1);
    wait_done("bp wr", 1, 1);
    chk("bp ar count", ar_addr_q.size(), 1);
    chk("bp araddr", ar_addr_q[0], 32'h300);
    chk("bp rdata", rdat_q[0], 128'h000000B3_000000B2_000000B1_000000B0);
    chk("bp rd_err", rerr_q[0], 1'b1);
    chk("bp beats", wd_q.size(), 4);
    for (int i = 0; i < 4 && i < wd_q.size(); i++) begin
      chk($sformatf("bp wdata%0d", i), wd_q[i], {4{8'hD0 + 8'(i)}});
      chk($sformatf("bp wlast%0d", i), wl_q[i], i == 3);
      chk($sformatf("bp wstrb%0d", i), wst_q[i], 4'hF);
    end
    chk("bp wr_err", werr_q[0], 1'b0);
    ar_stall = 0; wstall = 0; err_beat = -1;

    // reset during beat 1 of a read, then a clean read
    do_reset();
    rd_base = 32'hC0;
    issue(0, 0, 1, 3'd0, 32'h500, 0, 0);
    k = 0;
    while (!(rvalid && rdata == 32'hC1) && k < 100) begin
      @(negedge clk); #1; k++;
    end
    chk("mid beat1", k < 100, 1'b1);
    rst = 1;
    @(negedge clk); #1;
    chk("mid rst outs", {arvalid, awvalid, wvalid, rready, bready, wlast,
                         req_ready, rd_done, wr_done, rd_err, wr_err}, 0);
    chk("mid rst rd_data", rd_data, 0);
    @(negedge clk); #1 rst = 0;
    clear_logs();
    rd_base = 32'hE0;
    issue(0, 0, 1, 3'd0, 32'h508, 0, 0);
    wait_done("post rst rd", 0, 1);
    chk("post araddr", ar_addr_q[0], 32'h500);
    chk("post owner", rdd_q[0], 2'b01);
    chk("post data", rdat_q[0], 128'h000000E3_000000E2_000000E1_000000E0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
